// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings, sequencer state type and opcode legality helper
// for the ALU operation sequencer.
`timescale 1ns/1ps
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LSR = 4'd5;
    localparam logic [3:0] OP_LSL = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        RESP
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Request/response front end for a combinational N-bit ALU, including a
// shift-add multiply that iterates on the ALU adder.
`timescale 1ns/1ps
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_v,
    output logic         rsp_c,
    output logic         rsp_n,
    output logic         rsp_z,
    output logic         rsp_err,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_control,
    input  logic [N-1:0] alu_result,
    input  logic         alu_v,
    input  logic         alu_c,
    input  logic         alu_n,
    input  logic         alu_z
);

    // state | meaning
    // IDLE  | req_ready high, waiting for a request
    // EXEC  | single-cycle ALU op in flight, result captured at the edge
    // MUL   | shift-add multiply, one partial product per cycle for N cycles
    // RESP  | response loaded; rsp_valid rises one cycle later, held until taken

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  count;
    logic [N-1:0]   acc_next;

    // During MUL, alu_a is the accumulator and alu_b the shifted multiplicand.
    assign acc_next = mplier[0] ? alu_result : alu_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_v       <= 1'b0;
            rsp_c       <= 1'b0;
            rsp_n       <= 1'b0;
            rsp_z       <= 1'b0;
            rsp_err     <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= OP_ADD;
            mplier      <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (!is_legal_op(req_op)) begin
                            rsp_result <= '0;
                            rsp_v      <= 1'b0;
                            rsp_c      <= 1'b0;
                            rsp_n      <= 1'b0;
                            rsp_z      <= 1'b0;
                            rsp_err    <= 1'b1;
                            state      <= RESP;
                        end else if (req_op == OP_MUL) begin
                            alu_a       <= '0;
                            alu_b       <= req_a;
                            alu_control <= OP_ADD;
                            mplier      <= req_b;
                            count       <= '0;
                            state       <= MUL;
                        end else begin
                            alu_a       <= req_a;
                            alu_b       <= req_b;
                            alu_control <= req_op;
                            state       <= EXEC;
                        end
                    end
                end

                EXEC: begin
                    rsp_result  <= alu_result;
                    rsp_v       <= alu_v;
                    rsp_c       <= alu_c;
                    rsp_n       <= alu_n;
                    rsp_z       <= alu_z;
                    rsp_err     <= 1'b0;
                    alu_control <= OP_ADD;
                    state       <= RESP;
                end

                MUL: begin
                    alu_a  <= acc_next;
                    alu_b  <= alu_b << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        rsp_result <= acc_next;
                        rsp_v      <= 1'b0;
                        rsp_c      <= 1'b0;
                        rsp_n      <= acc_next[N-1];
                        rsp_z      <= (acc_next == '0);
                        rsp_err    <= 1'b0;
                        state      <= RESP;
                    end
                end

                RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Closed-loop bench: sequencer driving a behavioural ALU, checked against an
// integer-arithmetic reference model with directed and random requests.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int N = 4;
    localparam int M = 1 << N;
    localparam int H = M / 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic         rsp_v, rsp_c, rsp_n, rsp_z, rsp_err;
    logic [N-1:0] alu_a, alu_b;
    logic [3:0]   alu_control;
    logic [N-1:0] alu_result;
    logic         alu_v, alu_c, alu_n, alu_z;
    logic [N:0]   alu_wide;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_v       (rsp_v),
        .rsp_c       (rsp_c),
        .rsp_n       (rsp_n),
        .rsp_z       (rsp_z),
        .rsp_err     (rsp_err),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_v       (alu_v),
        .alu_c       (alu_c),
        .alu_n       (alu_n),
        .alu_z       (alu_z)
    );

    // Combinational ALU the sequencer talks to (carry on sub = no borrow).
    always_comb begin
        alu_wide   = '0;
        alu_result = '0;
        alu_v      = 1'b0;
        alu_c      = 1'b0;
        case (alu_control)
            4'd0: begin
                alu_wide   = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = alu_wide[N-1:0];
                alu_c      = alu_wide[N];
                alu_v      = (alu_a[N-1] == alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
            end
            4'd1: begin
                alu_wide   = {1'b0, alu_a} + {1'b0, ~alu_b} + {{N{1'b0}}, 1'b1};
                alu_result = alu_wide[N-1:0];
                alu_c      = alu_wide[N];
                alu_v      = (alu_a[N-1] != alu_b[N-1]) && (alu_result[N-1] != alu_a[N-1]);
            end
            4'd2: alu_result = alu_a & alu_b;
            4'd3: alu_result = alu_a | alu_b;
            4'd4: alu_result = alu_a ^ alu_b;
            4'd5: alu_result = alu_a >> alu_b;
            4'd6: alu_result = alu_a << alu_b;
            default: alu_result = '0;
        endcase
        alu_n = alu_result[N-1];
        alu_z = (alu_result == '0);
    end

    // Reference: plain integer arithmetic, signed overflow by range test.
    function automatic void ref_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                   output logic [N-1:0] r, output logic v, output logic c,
                                   output logic n, output logic z, output logic err);
        int ua, ub, sa, sb, full, sfull;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= H) ? ua - M : ua;
        sb = (ub >= H) ? ub - M : ub;
        full = 0; sfull = 0; v = 1'b0; c = 1'b0; err = 1'b0;
        case (op)
            OP_ADD: begin full = ua + ub; c = (full >= M); sfull = sa + sb; v = (sfull >= H) || (sfull < -H); end
            OP_SUB: begin full = ua - ub + M; c = (ua >= ub); sfull = sa - sb; v = (sfull >= H) || (sfull < -H); end
            OP_AND: full = ua & ub;
            OP_OR:  full = ua | ub;
            OP_XOR: full = ua ^ ub;
            OP_LSR: full = ua >> ub;
            OP_LSL: full = ua << ub;
            OP_MUL: full = ua * ub;
            default: err = 1'b1;
        endcase
        r = full[N-1:0];
        n = r[N-1];
        z = !err && (r == '0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input int hold, input string tag);
        logic [N-1:0] er;
        logic ev, ec, en, ez, ee;
        logic [31:0] exp_pk;
        int lat, exp_lat, guard;
        ref_op(op, a, b, er, ev, ec, en, ez, ee);
        exp_pk  = 32'({er, ev, ec, en, ez, ee});
        exp_lat = ee ? 1 : ((op == OP_MUL) ? N + 1 : 2);
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        rsp_ready = (hold == 0);
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        check({tag, " accept"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rsp"}, 32'({rsp_result, rsp_v, rsp_c, rsp_n, rsp_z, rsp_err}), exp_pk);
        check({tag, " busy"}, 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold"}, 32'({rsp_valid, req_ready, rsp_result, rsp_v, rsp_c, rsp_n, rsp_z, rsp_err}),
                  32'({2'b10, er, ev, ec, en, ez, ee}));
        end
        rsp_ready = 1'b1;
        check({tag, " rdy_low"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " release"}, 32'({rsp_valid, req_ready}), 32'b01);
    endtask

    initial begin
        logic [3:0]   b2b_op [3];
        logic [N-1:0] b2b_a [3];
        logic [N-1:0] b2b_b [3];
        logic [N-1:0] b2b_exp [3];
        logic ev, ec, en, ez, ee;
        int idx, got, outstanding, max_out, seen;
        logic acc_now, rsp_now;

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset rsp", 32'({rsp_valid, rsp_result, rsp_v, rsp_c, rsp_n, rsp_z, rsp_err}), 32'd0);
        check("reset alu", 32'({alu_a, alu_b, alu_control}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset ready", 32'(req_ready), 32'd1);

        run_op(OP_ADD, 4'b0111, 4'b0001, 0, "add_ovf");
        run_op(OP_SUB, 4'b0101, 4'b0101, 3, "sub_zero");
        run_op(OP_MUL, 4'b0011, 4'b0101, 0, "mul_3x5");
        run_op(OP_MUL, 4'b0110, 4'b0011, 1, "mul_wrap");
        run_op(4'b1010, 4'b1001, 4'b0110, 0, "illegal");

        // Abort a multiply with reset during its second iteration.
        @(negedge clk);
        req_op = OP_MUL; req_a = 4'b0011; req_b = 4'b0101; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst alu", 32'({alu_a, alu_b, alu_control}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("midrst no_rsp", 32'(seen), 32'd0);
        check("midrst ready", 32'(req_ready), 32'd1);
        run_op(OP_ADD, 4'b0010, 4'b0011, 0, "post_rst_add");

        // Back-to-back with req_valid held high.
        b2b_op[0] = OP_AND; b2b_a[0] = 4'b1100; b2b_b[0] = 4'b1010;
        b2b_op[1] = OP_LSL; b2b_a[1] = 4'b0001; b2b_b[1] = 4'd2;
        b2b_op[2] = OP_XOR; b2b_a[2] = 4'b1111; b2b_b[2] = 4'b0101;
        for (int i = 0; i < 3; i++) ref_op(b2b_op[i], b2b_a[i], b2b_b[i], b2b_exp[i], ev, ec, en, ez, ee);
        idx = 0; got = 0; outstanding = 0; max_out = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = b2b_op[0]; req_a = b2b_a[0]; req_b = b2b_b[0];
        for (int cyc = 0; cyc < 100 && got < 3; cyc++) begin
            acc_now = req_valid && req_ready;
            rsp_now = rsp_valid && rsp_ready;
            if (rsp_now) begin
                check($sformatf("b2b result%0d", got), 32'(rsp_result), 32'(b2b_exp[got]));
                got++;
                outstanding--;
            end
            if (acc_now) begin
                outstanding++;
                if (outstanding > max_out) max_out = outstanding;
            end
            @(negedge clk);
            if (acc_now) begin
                idx++;
                if (idx < 3) begin
                    req_op = b2b_op[idx]; req_a = b2b_a[idx]; req_b = b2b_b[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("b2b responses", 32'(got), 32'd3);
        check("b2b accepts", 32'(idx), 32'd3);
        check("b2b in_flight", 32'(max_out), 32'd1);

        for (int i = 0; i < 30; i++) begin
            logic [3:0] rop;
            rop = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            run_op(rop, N'($urandom), N'($urandom), int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
